// File: rtl/clk_mode_sw_ctrl.sv
// Sequences {enable, mode} changes onto the intcore clock switch cell without glitches:
// gate off, wait out synchronizer and ICG, flip mode, settle, re-enable. One request in flight at a time.
module clk_mode_sw_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int GUARD_CYC   = 2,
    parameter int SETTLE_CYC  = 4,
    parameter bit RST_MODE    = 1'b0,
    parameter int CNT_W       = 4
) (
    input  logic i_clk_ref,
    input  logic rst,
    input  logic req_valid,
    output logic req_ready,
    input  logic req_enable,
    input  logic req_mode,
    output logic intcore_clk_sw_enable,
    output logic intcore_clk_mode,
    output logic sw_busy,
    output logic sw_done
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GATE_OFF = 3'd1,
        SWITCH   = 3'd2,
        GATE_ON  = 3'd3,
        DONE     = 3'd4
    } state_t;

    // Counter preloads: each state lasts (load + 1) cycles.
    localparam logic [CNT_W-1:0] OFF_LD    = CNT_W'(SYNC_STAGES + GUARD_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] ON_LD     = CNT_W'(SYNC_STAGES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             lat_enable;
    logic             lat_mode;
    logic             lat_mode_chg;
    logic             accept;
    logic             mode_chg;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid & req_ready;
    assign mode_chg  = (req_mode != intcore_clk_mode);

    always_ff @(posedge i_clk_ref or posedge rst) begin
        if (rst) begin
            state                 <= IDLE;
            cnt                   <= '0;
            lat_enable            <= 1'b0;
            lat_mode              <= 1'b0;
            lat_mode_chg          <= 1'b0;
            intcore_clk_sw_enable <= 1'b1;
            intcore_clk_mode      <= RST_MODE;
            sw_busy               <= 1'b0;
            sw_done               <= 1'b0;
        end else begin
            sw_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        sw_busy      <= 1'b1;
                        lat_enable   <= req_enable;
                        lat_mode     <= req_mode;
                        lat_mode_chg <= mode_chg;
                        if (mode_chg && intcore_clk_sw_enable) begin
                            intcore_clk_sw_enable <= 1'b0;
                            cnt                   <= OFF_LD;
                            state                 <= GATE_OFF;
                        end else if (mode_chg) begin
                            // Clock already gated long ago: flip mode immediately.
                            intcore_clk_mode <= req_mode;
                            cnt              <= SETTLE_LD;
                            state            <= SWITCH;
                        end else if (req_enable == intcore_clk_sw_enable) begin
                            sw_done <= 1'b1;
                            state   <= DONE;
                        end else if (!req_enable) begin
                            intcore_clk_sw_enable <= 1'b0;
                            cnt                   <= OFF_LD;
                            state                 <= GATE_OFF;
                        end else begin
                            intcore_clk_sw_enable <= 1'b1;
                            cnt                   <= ON_LD;
                            state                 <= GATE_ON;
                        end
                    end
                end
                GATE_OFF: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (lat_mode_chg) begin
                        intcore_clk_mode <= lat_mode;
                        cnt              <= SETTLE_LD;
                        state            <= SWITCH;
                    end else begin
                        sw_done <= 1'b1;
                        state   <= DONE;
                    end
                end
                SWITCH: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (lat_enable) begin
                        intcore_clk_sw_enable <= 1'b1;
                        cnt                   <= ON_LD;
                        state                 <= GATE_ON;
                    end else begin
                        sw_done <= 1'b1;
                        state   <= DONE;
                    end
                end
                GATE_ON: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        sw_done <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    sw_busy <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    sw_busy <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_mode_sw_ctrl.sv
// Directed bench for clk_mode_sw_ctrl: per-cycle output traces against hand-derived timelines,
// plus a running mode-vs-enable invariant check on every sampled cycle.
module tb_clk_mode_sw_ctrl;

    localparam int GUARD_MIN = 4;  // SYNC_STAGES + GUARD_CYC with defaults

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req_valid = 1'b0;
    logic req_ready;
    logic req_enable = 1'b0;
    logic req_mode = 1'b0;
    logic en;
    logic mode;
    logic busy;
    logic done;

    int tests = 0;
    int fails = 0;

    logic [16:1] cap_en, cap_mode, cap_done, cap_busy, cap_rdy;
    logic [16:1] e_en, e_mode, e_done, e_busy, e_rdy;
    logic        pm, pe;
    bit          armed = 1'b0;
    int          low_cnt = 0;

    clk_mode_sw_ctrl dut (
        .i_clk_ref             (clk),
        .rst                   (rst),
        .req_valid             (req_valid),
        .req_ready             (req_ready),
        .req_enable            (req_enable),
        .req_mode              (req_mode),
        .intcore_clk_sw_enable (en),
        .intcore_clk_mode      (mode),
        .sw_busy               (busy),
        .sw_done               (done)
    );

    always #5 clk = ~clk;

    // Sample n cycles after an accept edge; cycle k lands in bit k. Also checks invariants.
    task automatic capture(input int n, input bit toggle_req);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            cap_en[k]   = en;
            cap_mode[k] = mode;
            cap_done[k] = done;
            cap_busy[k] = busy;
            cap_rdy[k]  = req_ready;
            if (armed && mode !== pm) begin
                tests++;
                assert (en === 1'b0 && pe === 1'b0 && low_cnt >= GUARD_MIN) else begin
                    fails++;
                    $display("FAIL inv_mode_gated cyc%0d en=%b prev_en=%b low=%0d need>=%0d",
                             k, en, pe, low_cnt, GUARD_MIN);
                end
                tests++;
                assert (en === pe) else begin
                    fails++;
                    $display("FAIL inv_same_cycle cyc%0d en %b->%b with mode change", k, pe, en);
                end
            end
            low_cnt = en ? 0 : ((low_cnt < 100) ? low_cnt + 1 : 100);
            pm      = mode;
            pe      = en;
            armed   = 1'b1;
            if (toggle_req) begin
                if (k < 12) begin
                    req_mode   = ~req_mode;
                    req_enable = ~req_enable;
                end else if (k == 12) begin
                    req_mode   = 1'b1;
                    req_enable = 1'b1;
                end else if (k == 13) begin
                    req_valid = 1'b0;
                end
            end
        end
    endtask

    task automatic issue(input logic r_en, input logic r_mode);
        @(negedge clk);
        req_valid  = 1'b1;
        req_enable = r_en;
        req_mode   = r_mode;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic compare_all(input string name);
        for (int k = 1; k <= 16; k++) begin
            tests += 5;
            if (cap_en[k] !== e_en[k]) begin
                fails++; $display("FAIL %s enable@%0d got %b exp %b", name, k, cap_en[k], e_en[k]);
            end
            if (cap_mode[k] !== e_mode[k]) begin
                fails++; $display("FAIL %s mode@%0d got %b exp %b", name, k, cap_mode[k], e_mode[k]);
            end
            if (cap_done[k] !== e_done[k]) begin
                fails++; $display("FAIL %s done@%0d got %b exp %b", name, k, cap_done[k], e_done[k]);
            end
            if (cap_busy[k] !== e_busy[k]) begin
                fails++; $display("FAIL %s busy@%0d got %b exp %b", name, k, cap_busy[k], e_busy[k]);
            end
            if (cap_rdy[k] !== e_rdy[k]) begin
                fails++; $display("FAIL %s ready@%0d got %b exp %b", name, k, cap_rdy[k], e_rdy[k]);
            end
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        tests += 5;
        if (en !== 1'b1)        begin fails++; $display("FAIL reset enable got %b exp 1", en); end
        if (mode !== 1'b0)      begin fails++; $display("FAIL reset mode got %b exp 0", mode); end
        if (done !== 1'b0)      begin fails++; $display("FAIL reset done got %b exp 0", done); end
        if (busy !== 1'b0)      begin fails++; $display("FAIL reset busy got %b exp 0", busy); end
        if (req_ready !== 1'b1) begin fails++; $display("FAIL reset ready got %b exp 1", req_ready); end
        rst = 1'b0;
    endtask

    // Enabled, mode 0 -> 1, keep enabled: full gate/switch/re-enable sequence.
    task automatic test_mode_switch;
        issue(1'b1, 1'b1);
        capture(16, 1'b0);
        e_en = 16'hFF00; e_mode = 16'hFFF0; e_done = 16'h0400; e_busy = 16'h07FF; e_rdy = 16'hF800;
        compare_all("mode_switch");
    endtask

    task automatic test_noop;
        issue(1'b1, 1'b1);
        capture(16, 1'b0);
        e_en = 16'hFFFF; e_mode = 16'hFFFF; e_done = 16'h0001; e_busy = 16'h0001; e_rdy = 16'hFFFE;
        compare_all("noop");
    endtask

    // Enabled mode 1 -> mode 0 and stay disabled.
    task automatic test_switch_and_disable;
        issue(1'b0, 1'b0);
        capture(16, 1'b0);
        e_en = 16'h0000; e_mode = 16'h000F; e_done = 16'h0100; e_busy = 16'h01FF; e_rdy = 16'hFE00;
        compare_all("switch_disable");
    endtask

    // From disabled: mode flips at once with no gate-off wait, then optionally re-enable.
    task automatic test_switch_from_disabled;
        issue(1'b0, 1'b1);
        capture(16, 1'b0);
        e_en = 16'h0000; e_mode = 16'hFFFF; e_done = 16'h0010; e_busy = 16'h001F; e_rdy = 16'hFFE0;
        compare_all("switch_dis_stay");
        issue(1'b1, 1'b0);
        capture(16, 1'b0);
        e_en = 16'hFFF0; e_mode = 16'h0000; e_done = 16'h0040; e_busy = 16'h007F; e_rdy = 16'hFF80;
        compare_all("switch_dis_enable");
    endtask

    task automatic test_gate_only;
        issue(1'b0, 1'b0);
        capture(16, 1'b0);
        e_en = 16'h0000; e_mode = 16'h0000; e_done = 16'h0010; e_busy = 16'h001F; e_rdy = 16'hFFE0;
        compare_all("gate_off_only");
        issue(1'b1, 1'b0);
        capture(16, 1'b0);
        e_en = 16'hFFFF; e_mode = 16'h0000; e_done = 16'h0004; e_busy = 16'h0007; e_rdy = 16'hFFF8;
        compare_all("gate_on_only");
    endtask

    // Request held with toggling fields while busy; second request lands after ready returns.
    task automatic test_back_to_back;
        @(negedge clk);
        req_valid  = 1'b1;
        req_enable = 1'b1;
        req_mode   = 1'b1;
        @(posedge clk);
        capture(16, 1'b1);
        e_en = 16'hFF00; e_mode = 16'hFFF0; e_done = 16'h1400; e_busy = 16'h17FF; e_rdy = 16'hE800;
        compare_all("back_to_back");
    endtask

    task automatic test_reset_mid_seq;
        rst = 1'b1;
        armed = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        issue(1'b1, 1'b1);
        capture(6, 1'b0);
        #1 rst = 1'b1;
        armed = 1'b0;
        #1;
        tests += 4;
        if (en !== 1'b1)   begin fails++; $display("FAIL midrst enable got %b exp 1", en); end
        if (mode !== 1'b0) begin fails++; $display("FAIL midrst mode got %b exp 0", mode); end
        if (busy !== 1'b0) begin fails++; $display("FAIL midrst busy got %b exp 0", busy); end
        if (done !== 1'b0) begin fails++; $display("FAIL midrst done got %b exp 0", done); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        capture(16, 1'b0);
        e_en = 16'hFFFF; e_mode = 16'h0000; e_done = 16'h0000; e_busy = 16'h0000; e_rdy = 16'hFFFF;
        compare_all("after_midrst");
    endtask

    initial begin
        test_reset;
        test_mode_switch;
        test_noop;
        test_switch_and_disable;
        test_switch_from_disabled;
        test_gate_only;
        test_back_to_back;
        test_reset_mid_seq;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
